// File: rtl/wlm_pkg.sv
// Shared definitions for the word-level Montgomery reducer: FSM states and
// helpers deriving the word width W and the word-step count L.
package wlm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_CORR   = 2'd2,
    ST_DONE   = 2'd3
  } wlm_state_e;

  function automatic int calc_w(input int logq, input int logqh);
    return logq - logqh;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/wlm_iter_step.sv
// One Montgomery word step for q = qH*2^W + 1: since q == 1 mod 2^W the
// quotient digit is just -A mod 2^W, and the low word folds into a carry bit.
module wlm_iter_step
  import wlm_pkg::*;
#(
  parameter int LOGQ  = 60,
  parameter int LOGQH = 43
) (
  input  logic [2*LOGQ:0]  a_i,
  input  logic [LOGQH-1:0] qh_i,
  output logic [2*LOGQ:0]  a_o
);

  localparam int W  = calc_w(LOGQ, LOGQH);
  localparam int AW = 2*LOGQ + 1;

  logic [W-1:0] m_s;
  logic         nz_s;

  assign m_s  = W'(0) - a_i[W-1:0];
  assign nz_s = (a_i[W-1:0] != W'(0));
  assign a_o  = (a_i >> W) + (AW'(m_s) * AW'(qh_i)) + AW'(nz_s);

endmodule

// File: rtl/wlm_iter.sv
// Iterative word-level Montgomery reducer: T = C * 2^(-W*L) mod q, with a
// per-channel qH table and a valid/ready handshake on both sides.
module wlm_iter
  import wlm_pkg::*;
#(
  parameter int LOGQ    = 60,
  parameter int LOGQH   = 43,
  parameter int NCH     = 4,
  parameter int TAGW    = 8,
  parameter int CORRECT = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_we,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [LOGQH-1:0]                    cfg_qH,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] in_ch,
  input  logic [2*LOGQ-1:0]                   in_C,
  input  logic [TAGW-1:0]                     in_tag,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LOGQ-1:0]                     out_T,
  output logic [TAGW-1:0]                     out_tag,
  output logic                                out_err
);

  localparam int W    = calc_w(LOGQ, LOGQH);
  localparam int L    = ceil_div(LOGQ, W);
  localparam int LAT  = L + CORRECT;
  localparam int AW   = 2*LOGQ + 1;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(L + 1);

  wlm_state_e       state_q;
  logic [AW-1:0]    a_q;
  logic [LOGQH-1:0] qh_q;
  logic [TAGW-1:0]  tag_q;
  logic             err_q;
  logic [CNTW-1:0]  cnt_q;
  logic             out_valid_q;
  logic [LOGQ-1:0]  out_t_q;
  logic [TAGW-1:0]  out_tag_q;
  logic             out_err_q;
  logic [LOGQH-1:0] tbl_q [NCH];

  logic             accept_s;
  logic             in_ok_s;
  logic             cfg_ok_s;
  logic [LOGQH-1:0] qh_sel_s;
  logic [AW-1:0]    q_s;
  logic [AW-1:0]    a_step_d;
  logic [AW-1:0]    t_corr_d;

  assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign in_ok_s   = ({1'b0, in_ch} < (CHW+1)'(NCH));
  assign cfg_ok_s  = ({1'b0, cfg_ch} < (CHW+1)'(NCH));
  assign qh_sel_s  = in_ok_s ? tbl_q[in_ch] : LOGQH'(0);
  assign q_s       = AW'({qh_q, W'(0)}) + AW'(1);
  assign t_corr_d  = (a_q >= q_s) ? (a_q - q_s) : a_q;

  assign out_valid = out_valid_q;
  assign out_T     = out_t_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

  wlm_iter_step #(.LOGQ(LOGQ), .LOGQH(LOGQH)) u_step (
    .a_i  (a_q),
    .qh_i (qh_q),
    .a_o  (a_step_d)
  );

  // qH table; an accept in the same cycle still reads the old entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) tbl_q[i] <= LOGQH'(0);
    end else if (cfg_we && cfg_ok_s) begin
      tbl_q[cfg_ch] <= cfg_qH;
    end
  end

  // Operation FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= AW'(0);
      qh_q        <= LOGQH'(0);
      tag_q       <= TAGW'(0);
      err_q       <= 1'b0;
      cnt_q       <= CNTW'(0);
      out_valid_q <= 1'b0;
      out_t_q     <= LOGQ'(0);
      out_tag_q   <= TAGW'(0);
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            a_q     <= AW'(in_C);
            qh_q    <= qh_sel_s;
            tag_q   <= in_tag;
            err_q   <= !in_ok_s;
            cnt_q   <= CNTW'(0);
            state_q <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          a_q   <= a_step_d;
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(L - 1)) begin
            if (CORRECT != 0) begin
              state_q <= ST_CORR;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_t_q     <= err_q ? LOGQ'(0) : LOGQ'(a_step_d);
              out_tag_q   <= tag_q;
              out_err_q   <= err_q;
            end
          end
        end
        ST_CORR: begin
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
          out_t_q     <= err_q ? LOGQ'(0) : LOGQ'(t_corr_d);
          out_tag_q   <= tag_q;
          out_err_q   <= err_q;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept_s) begin
              a_q     <= AW'(in_C);
              qh_q    <= qh_sel_s;
              tag_q   <= in_tag;
              err_q   <= !in_ok_s;
              cnt_q   <= CNTW'(0);
              state_q <= ST_REDUCE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
